// File: rtl/run_seq_pkg.sv
// ---------------------------------------------------------------------------
// run_seq_pkg
// Shared definitions for the CPU run sequencer:
//   - run_state_t   : sequencer FSM states (encoding is visible on the debug
//                     LEDs, so the values are fixed)
//   - width constants for the program, speed, address and prescaler fields
//   - divider widths per run-rate code, and helpers that turn them into a
//     prescaler mask
//   - prog_addr()   : program entry address from base, stride and selection
// ---------------------------------------------------------------------------
package run_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } run_state_t;

    localparam int PROG_W  = 4;
    localparam int SPEED_W = 2;
    localparam int ADDR_W  = 16;
    localparam int PRESC_W = 5;

    // Number of low prescaler bits that must all be ones for an enable.
    // One enable every 2**k clk.
    localparam int DIV_W_00 = 5;
    localparam int DIV_W_01 = 4;
    localparam int DIV_W_10 = 3;
    localparam int DIV_W_11 = 2;

    function automatic int speed_div_w(input logic [SPEED_W-1:0] speed);
        int k;
        unique case (speed)
            2'd0:    k = DIV_W_00;
            2'd1:    k = DIV_W_01;
            2'd2:    k = DIV_W_10;
            default: k = DIV_W_11;
        endcase
        return k;
    endfunction

    function automatic logic [PRESC_W-1:0] speed_mask(input logic [SPEED_W-1:0] speed);
        logic [31:0] full;
        full = (32'd1 << speed_div_w(speed)) - 32'd1;
        return full[PRESC_W-1:0];
    endfunction

    // 16-bit result; wraps modulo 2**16 by construction.
    function automatic logic [ADDR_W-1:0] prog_addr(
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] stride,
        input logic [PROG_W-1:0] sel
    );
        logic [ADDR_W-1:0] sel_ext;
        sel_ext = {{(ADDR_W-PROG_W){1'b0}}, sel};
        return base + stride * sel_ext;
    endfunction

endpackage

// File: rtl/cpu_run_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_run_sequencer_if
// Bundles the board-side inputs and the CPU-side outputs of the run
// sequencer.
//   master : the sequencer (reads switches/buttons, drives CPU controls)
//   slave  : the board/CPU environment (drives switches/buttons, reads
//            CPU controls)
// Signals:
//   prog_sel[3:0], speed_sel[1:0], step_mode, start_btn, step_btn : raw,
//       asynchronous board inputs
//   cpu_rst_n, cpu_clk_en, start_address[15:0] : CPU system controls
//   current_program[3:0], program_running, seq_state[1:0] : status/debug
// Optional (macro RUN_SEQ_BREAKPOINT_EN): bp_addr[15:0], bp_valid,
//   cpu_pc[15:0] from the CPU/debug side.
//
// Handshake: cpu_clk_en is a one-clk strobe with no back-pressure. The CPU
// advances exactly one of its cycles for every clk on which cpu_clk_en is
// high; there is no ready signal, and the strobe is never high while
// cpu_rst_n is low.
// ---------------------------------------------------------------------------
interface cpu_run_sequencer_if;
    import run_seq_pkg::*;

    logic [PROG_W-1:0]  prog_sel;
    logic [SPEED_W-1:0] speed_sel;
    logic               step_mode;
    logic               start_btn;
    logic               step_btn;

    logic               cpu_rst_n;
    logic               cpu_clk_en;
    logic [ADDR_W-1:0]  start_address;
    logic [PROG_W-1:0]  current_program;
    logic               program_running;
    logic [1:0]         seq_state;

`ifdef RUN_SEQ_BREAKPOINT_EN
    logic [ADDR_W-1:0]  bp_addr;
    logic               bp_valid;
    logic [ADDR_W-1:0]  cpu_pc;
`endif

    modport master (
`ifdef RUN_SEQ_BREAKPOINT_EN
        input  bp_addr,
        input  bp_valid,
        input  cpu_pc,
`endif
        input  prog_sel,
        input  speed_sel,
        input  step_mode,
        input  start_btn,
        input  step_btn,
        output cpu_rst_n,
        output cpu_clk_en,
        output start_address,
        output current_program,
        output program_running,
        output seq_state
    );

    modport slave (
`ifdef RUN_SEQ_BREAKPOINT_EN
        output bp_addr,
        output bp_valid,
        output cpu_pc,
`endif
        output prog_sel,
        output speed_sel,
        output step_mode,
        output start_btn,
        output step_btn,
        input  cpu_rst_n,
        input  cpu_clk_en,
        input  start_address,
        input  current_program,
        input  program_running,
        input  seq_state
    );

endinterface

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
// Two-flop synchroniser, stability counter, debounced level and a one-cycle
// press pulse on each debounced 0->1 transition.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_i      : raw, bouncy, asynchronous button level
//   press_o    : one-clk pulse per accepted press
// The counter runs only while the synchronised level differs from the
// debounced level and clears as soon as they agree again, so any bounce back
// restarts the stability window. A clean raw edge produces press_o
// STABLE_CYCLES+3 clk later (2 sync stages, STABLE_CYCLES of counting, one
// update cycle).
// ---------------------------------------------------------------------------
module button_debouncer #(
    parameter int unsigned STABLE_CYCLES = 270000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/cpu_run_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_run_sequencer
// Execution controller for the 6502 CPU system: debounces start/step,
// latches the program selection, holds the CPU in reset for RESET_CYCLES
// and then gates CPU progress with a one-clk enable, either at a
// switch-selected rate (free run) or once per step press (single step).
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : cpu_run_sequencer_if.master (switches, buttons, CPU
//                controls, status/debug; see the interface file)
// Optional feature, macro RUN_SEQ_BREAKPOINT_EN: a PC breakpoint that
// suppresses the enable and parks the FSM in HALT, where each step press
// gives one enable. Without the macro HALT is unreachable.
// ---------------------------------------------------------------------------
module cpu_run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned       DEBOUNCE_CYCLES = 270000,
    parameter int unsigned       RESET_CYCLES    = 16,
    parameter logic [15:0]       PROG_BASE       = 16'h8000,
    parameter logic [15:0]       PROG_STRIDE     = 16'h0100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cpu_run_sequencer_if.master  bus
);

    localparam int RST_CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RST_CNT_W-1:0] RST_LOAD = RST_CNT_W'(RESET_CYCLES - 1);
    localparam int SW_W = PROG_W + SPEED_W + 1;

    // Level switches share one synchroniser; they are quasi-static, so a
    // momentary mix of old and new bits only lasts one clk.
    logic [SW_W-1:0]     sw_sync1_q, sw_sync2_q;
    logic [PROG_W-1:0]   prog_sel_s;
    logic [SPEED_W-1:0]  speed_sel_s;
    logic                step_mode_s;

    logic                start_press, step_press;

    run_state_t          state_q, state_d;
    logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [PROG_W-1:0]   prog_q, prog_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [PRESC_W-1:0]  presc_q;

    logic                presc_hit;
    logic                would_en;
    logic                bp_hit;
    logic                clk_en_c;

    assign {prog_sel_s, speed_sel_s, step_mode_s} = sw_sync2_q;

    button_debouncer #(.STABLE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (bus.start_btn),
        .press_o (start_press)
    );

    button_debouncer #(.STABLE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (bus.step_btn),
        .press_o (step_press)
    );

    // Free-running prescaler; the rate only selects which low bits are
    // compared, so a speed change never restarts the count.
    assign presc_hit = ((presc_q & speed_mask(speed_sel_s)) == speed_mask(speed_sel_s));
    assign would_en  = step_mode_s ? step_press : presc_hit;

`ifdef RUN_SEQ_BREAKPOINT_EN
    // cpu_pc is produced by the CPU in this clock domain, no sync needed.
    assign bp_hit = bus.bp_valid && (bus.cpu_pc == bus.bp_addr);
`else
    assign bp_hit = 1'b0;
`endif

    // Next-state logic. A start press wins over everything else in every
    // state: it relatches the selection, reloads the reset window and
    // leaves the enable low for that cycle.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        prog_d    = prog_q;
        addr_d    = addr_q;
        clk_en_c  = 1'b0;

        if (start_press) begin
            prog_d    = prog_sel_s;
            addr_d    = prog_addr(PROG_BASE, PROG_STRIDE, prog_sel_s);
            rst_cnt_d = RST_LOAD;
            state_d   = RESET;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RESET: begin
                    if (rst_cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        rst_cnt_d = rst_cnt_q - 1'b1;
                    end
                end
                RUN: begin
                    if (would_en && bp_hit) begin
                        state_d = HALT;
                    end else begin
                        clk_en_c = would_en;
                    end
                end
                HALT: begin
`ifdef RUN_SEQ_BREAKPOINT_EN
                    // A step advances one cycle even if the PC still matches.
                    clk_en_c = step_press;
`else
                    state_d = IDLE;
`endif
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
            state_q    <= IDLE;
            rst_cnt_q  <= '0;
            prog_q     <= '0;
            addr_q     <= PROG_BASE;
            presc_q    <= '0;
        end else begin
            sw_sync1_q <= {bus.prog_sel, bus.speed_sel, bus.step_mode};
            sw_sync2_q <= sw_sync1_q;
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            prog_q     <= prog_d;
            addr_q     <= addr_d;
            presc_q    <= presc_q + 1'b1;
        end
    end

    // CPU is out of reset only in RUN and HALT, so the enable (only ever
    // produced in those states) can never coincide with cpu_rst_n low.
    assign bus.cpu_rst_n       = (state_q == RUN) || (state_q == HALT);
    assign bus.cpu_clk_en      = clk_en_c;
    assign bus.start_address   = addr_q;
    assign bus.current_program = prog_q;
    assign bus.program_running = (state_q == RUN);
    assign bus.seq_state       = state_q;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
`timescale 1ns/1ps
module tb_cpu_run_sequencer;

    localparam int DEB     = 4;
    localparam int RST_LEN = 16;

    localparam logic [1:0] K_EN  = 2'd1;
    localparam logic [1:0] K_REL = 2'd2;

    // Expected DUT events. K_EN: a = required gap since previous enable
    // (0 = any). K_REL: a = start_address, b = current_program.
    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_run_sequencer_if bus();

    cpu_run_sequencer #(
        .DEBOUNCE_CYCLES (DEB),
        .RESET_CYCLES    (RST_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    function automatic logic [15:0] model_addr(input int sel);
        logic [31:0] full;
        full = 32'h8000 + 32'(sel) * 32'h0100;
        return full[15:0];
    endfunction

    function automatic int model_period(input int speed);
        return 32 >> speed;
    endfunction

    function automatic exp_t mk(input logic [1:0] k, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic prev_cpu_rst_n = 1'b0;
    int   reset_len = 0;
    int   gap = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            reset_len      = 0;
            gap            = 0;
            prev_cpu_rst_n = 1'b0;
        end else begin
            gap++;
            if (bus.seq_state == 2'd1) reset_len++;
            else if (bus.seq_state == 2'd0) reset_len = 0;

            if (bus.cpu_clk_en === 1'b1) begin
                check("en_cpu_out_of_reset", 32'(bus.cpu_rst_n), 32'd1);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_enable: got cpu_clk_en=1 at %0t, required 0", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("en_event_kind", 32'(K_EN), 32'(mon_e.kind));
                    if (mon_e.a != 16'd0) check("en_period", 32'(gap), 32'(mon_e.a));
                end
                gap = 0;
            end

            if (bus.cpu_rst_n === 1'b1 && prev_cpu_rst_n === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_release: got cpu_rst_n rising at %0t, required none", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rel_event_kind", 32'(K_REL), 32'(mon_e.kind));
                    check("rel_start_address", 32'(bus.start_address), 32'(mon_e.a));
                    check("rel_current_program", 32'(bus.current_program), 32'(mon_e.b));
                    check("rel_program_running", 32'(bus.program_running), 32'd1);
                    check("rel_seq_state", 32'(bus.seq_state), 32'd2);
                    check("rel_reset_len", 32'(reset_len), 32'(RST_LEN));
                end
                reset_len = 0;
            end
            prev_cpu_rst_n = bus.cpu_rst_n;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_drain(input int budget, input string what);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_%s: got %0d events pending after %0d clk, required 0", what, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic buttons(input logic s, input logic t);
        bus.start_btn = s;
        bus.step_btn  = t;
        tick(DEB + 6);
        bus.start_btn = 1'b0;
        bus.step_btn  = 1'b0;
        tick(DEB + 6);
    endtask

    task automatic press_start(input int sel, input bit bounce);
        bus.prog_sel = 4'(sel);
        tick(4);
        exp_q.push_back(mk(K_REL, model_addr(sel), 16'(sel)));
        if (bounce) begin
            for (int i = 0; i < 10; i++) begin
                bus.start_btn = (i % 2 == 0);
                tick(2);
            end
        end
        buttons(1'b1, 1'b0);
        wait_drain(100, "start");
    endtask

    task automatic press_step();
        exp_q.push_back(mk(K_EN, 16'd0, 16'd0));
        buttons(1'b0, 1'b1);
        wait_drain(60, "step");
    endtask

    // Free run at a given rate for n enables, then park in step mode.
    task automatic free_run(input int speed, input int n);
        bus.speed_sel = 2'(speed);
        bus.step_mode = 1'b0;
        exp_q.push_back(mk(K_EN, 16'd0, 16'd0));
        for (int i = 1; i < n; i++) exp_q.push_back(mk(K_EN, 16'(model_period(speed)), 16'd0));
        wait_drain(n * 32 + 60, "free_run");
        bus.step_mode = 1'b1;
        tick(4);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cpu_rst_n"}, 32'(bus.cpu_rst_n), 32'd0);
        check({tag, "_cpu_clk_en"}, 32'(bus.cpu_clk_en), 32'd0);
        check({tag, "_start_address"}, 32'(bus.start_address), 32'h8000);
        check({tag, "_current_program"}, 32'(bus.current_program), 32'd0);
        check({tag, "_program_running"}, 32'(bus.program_running), 32'd0);
        check({tag, "_seq_state"}, 32'(bus.seq_state), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: still running at %0t, required finish", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        int sel;
        int t;
        bus.prog_sel  = 4'h0;
        bus.speed_sel = 2'd0;
        bus.step_mode = 1'b1;
        bus.start_btn = 1'b0;
        bus.step_btn  = 1'b0;
`ifdef RUN_SEQ_BREAKPOINT_EN
        bus.bp_addr  = 16'h0000;
        bus.bp_valid = 1'b0;
        bus.cpu_pc   = 16'h0000;
`endif
        rst_n = 1'b0;
        tick(5);
        check_reset_values("in_reset");
        rst_n = 1'b1;
        tick(100);
        check_reset_values("idle");

        // Bouncy start press selecting program 3.
        press_start(3, 1'b1);
        check("run_start_address", 32'(bus.start_address), 32'h8300);
        check("run_program_running", 32'(bus.program_running), 32'd1);

        // Run rates: slowest then fastest, then random ones.
        free_run(0, 4);
        free_run(3, 5);
        for (int r = 0; r < 4; r++) free_run(int'($urandom_range(0, 3)), int'($urandom_range(2, 5)));
        check("still_run", 32'(bus.seq_state), 32'd2);

        // Single step: three presses, then a random number more.
        for (int i = 0; i < 3; i++) begin
            press_step();
            tick(int'($urandom_range(0, 7)));
        end
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) press_step();

        // Start and step in the same cycle: restart only, no enable.
        sel = int'($urandom_range(0, 15));
        bus.prog_sel = 4'(sel);
        tick(4);
        exp_q.push_back(mk(K_REL, model_addr(sel), 16'(sel)));
        buttons(1'b1, 1'b1);
        wait_drain(100, "start_and_step");

        // Restart from RUN with program F, then random restarts.
        press_start(15, 1'b0);
        check("restart_f_address", 32'(bus.start_address), 32'h8F00);
        for (int i = 0; i < 3; i++) begin
            press_start(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)) == 1);
            press_step();
        end

        // Asynchronous reset in the middle of the reset window.
        bus.prog_sel = 4'(int'($urandom_range(1, 15)));
        tick(4);
        bus.start_btn = 1'b1;
        t = 0;
        while (bus.seq_state != 2'd1 && t < 40) begin
            tick(1);
            t++;
        end
        check("enter_reset_state", 32'(bus.seq_state), 32'd1);
        tick(5);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_reset_values("async_reset");
        bus.start_btn = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(20);
        check("after_reset_idle", 32'(bus.seq_state), 32'd0);
        check("after_reset_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);

`ifdef RUN_SEQ_BREAKPOINT_EN
        press_start(3, 1'b0);
        bus.bp_addr   = 16'h8305;
        bus.cpu_pc    = 16'h8305;
        bus.bp_valid  = 1'b1;
        bus.speed_sel = 2'd3;
        bus.step_mode = 1'b0;
        tick(60);
        check("bp_halt_state", 32'(bus.seq_state), 32'd3);
        check("bp_halt_running", 32'(bus.program_running), 32'd0);
        check("bp_halt_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd1);
        press_step();
        check("bp_after_step_state", 32'(bus.seq_state), 32'd3);
        bus.bp_valid  = 1'b0;
        bus.step_mode = 1'b1;
        press_start(5, 1'b0);
        check("bp_restart_state", 32'(bus.seq_state), 32'd2);
`endif

        tick(20);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
